// File: rtl/sum_to_7seg_driver_if.sv
// Connects the adder-side producer to the 7-segment driver.
// It carries the value and load strobe in, and the busy status and display drive out.
interface sum_to_7seg_driver_if #(
    parameter int W      = 4,
    parameter int DIGITS = 2
) ();
    logic [W-1:0]      sum_in;
    logic              load;
    logic              busy;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;

    modport master (output sum_in, output load, input busy, input seg, input an);
    modport slave  (input sum_in, input load, output busy, output seg, output an);
endinterface

// File: rtl/sum_to_7seg_driver.sv
// Captures an adder sum on load and converts it to BCD, one double-dabble step per clock.
// It then scans the held result onto a multiplexed common-anode 7-segment display.
module sum_to_7seg_driver #(
    parameter int W           = 4,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    sum_to_7seg_driver_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int XW = (W > 32) ? W : 32;
    localparam logic [XW-1:0] LIM_X = XW'(10 ** DIGITS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_UPD  = 2'd2;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [W-1:0]      r_bin;
    logic [BW-1:0]     r_bcd;
    logic              r_ovf;
    logic [BW-1:0]     r_disp;
    logic              r_disp_ovf;
    logic [RW-1:0]     r_refresh;
    logic [DW-1:0]     r_digit;

    logic              w_ovf_in;
    logic [BW-1:0]     w_adj;
    logic [BW+W-1:0]   w_shift;
    logic [DW-1:0]     w_msd;
    logic [3:0]        w_nib;
    logic [6:0]        w_seg_n;
    logic [DIGITS-1:0] w_an_hot;

    function automatic logic [BW-1:0] dd_adjust(input logic [BW-1:0] v);
        logic [BW-1:0] v_out;
        v_out = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5)
                v_out[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return v_out;
    endfunction

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_glyph_n(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign w_ovf_in = (XW'(bus.sum_in) >= LIM_X);
    assign w_adj    = dd_adjust(r_bcd);
    assign w_shift  = {w_adj, r_bin} << 1;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_disp     <= '0;
            r_disp_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.load) r_state <= S_CONV;
                S_CONV: if (r_cnt == CW'(W - 1)) r_state <= S_UPD;
                S_UPD: begin
                    r_state    <= S_IDLE;
                    r_disp     <= r_bcd;
                    r_disp_ovf <= r_ovf;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Conversion datapath needs no reset: the FSM gates every use of it.
    always_ff @(posedge i_clk) begin
        if (r_state == S_IDLE && bus.load) begin
            r_bin <= bus.sum_in;
            r_bcd <= '0;
            r_ovf <= w_ovf_in;
            r_cnt <= '0;
        end else if (r_state == S_CONV) begin
            r_bcd <= w_shift[BW+W-1:W];
            r_bin <= w_shift[W-1:0];
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_refresh <= '0;
            r_digit   <= '0;
        end else if (r_refresh == RW'(REFRESH_DIV - 1)) begin
            r_refresh <= '0;
            r_digit   <= (r_digit == DW'(DIGITS - 1)) ? '0 : r_digit + 1'b1;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    // Highest nonzero digit; digits above it are blanked.
    always_comb begin
        w_msd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_disp[4*i +: 4] != 4'd0)
                w_msd = DW'(i);
        end
    end

    assign w_nib = r_disp[4*r_digit +: 4];

    always_comb begin
        w_seg_n = 7'b1111111;
        if (r_disp_ovf)
            w_seg_n = 7'b0111111;
        else if (r_digit <= w_msd)
            w_seg_n = seg_glyph_n(w_nib);
    end

    assign w_an_hot = DIGITS'(1) << r_digit;
    assign bus.busy = (r_state != S_IDLE);
    assign bus.seg  = (ACTIVE_LOW != 0) ? w_seg_n : ~w_seg_n;
    assign bus.an   = (ACTIVE_LOW != 0) ? ~w_an_hot : w_an_hot;
endmodule
